// File: rtl/servo_pwm_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_driver_if
//  Description : Bundle between the angle output unit and the servo PWM
//                driver: four target angles and an enable in, four PWM pins,
//                the slewed positions and frame status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface servo_pwm_driver_if;
  logic [7:0] angle1;
  logic [7:0] angle2;
  logic [7:0] angle3;
  logic [7:0] angle4;
  logic       en;
  logic [3:0] pwm;
  logic [7:0] cur_angle1;
  logic [7:0] cur_angle2;
  logic [7:0] cur_angle3;
  logic [7:0] cur_angle4;
  logic       frame_start;
  logic       settled;

  // Upstream side: supplies targets and enable, observes the servo outputs.
  modport master (
    output angle1, angle2, angle3, angle4, en,
    input  pwm, cur_angle1, cur_angle2, cur_angle3, cur_angle4,
    input  frame_start, settled
  );

  // Driver side.
  modport slave (
    input  angle1, angle2, angle3, angle4, en,
    output pwm, cur_angle1, cur_angle2, cur_angle3, cur_angle4,
    output frame_start, settled
  );
endinterface
`default_nettype wire

// File: rtl/servo_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pwm_driver
//  Description : Four-channel hobby-servo PWM generator. Once per frame each
//                channel's position slews toward its clamped target by at most
//                SLEW_STEP degrees; the pulse width is MIN_CYC + cur*DEG_CYC.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_driver #(
  parameter int FRAME_CYC  = 1_000_000,
  parameter int MIN_CYC    = 50_000,
  parameter int DEG_CYC    = 278,
  parameter int SLEW_STEP  = 2,
  parameter int INIT_ANGLE = 90
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  servo_pwm_driver_if.slave  bus
);

  // Counter width covers 0..FRAME_CYC-1; pulse width must also hold FRAME_CYC
  // itself so a full-frame pulse is representable.
  localparam int CW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int WW = $clog2(FRAME_CYC + 1);

  localparam logic [CW-1:0] c_last  = CW'(FRAME_CYC - 1);
  localparam logic [WW-1:0] c_min   = WW'(MIN_CYC);
  localparam logic [WW-1:0] c_deg   = WW'(DEG_CYC);
  localparam logic [8:0]    c_step  = 9'(SLEW_STEP);
  localparam logic [7:0]    c_step8 = 8'(SLEW_STEP);
  localparam logic [7:0]    c_max   = 8'd180;
  localparam logic [7:0]    c_init  = 8'(INIT_ANGLE);

  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic                  w_boundary;
  logic                  r_active;
  logic                  w_active_next;
  logic [3:0][7:0]       w_raw;
  logic [3:0][7:0]       w_tgt;
  logic [3:0][8:0]       w_diff;
  logic [3:0][8:0]       w_mag;
  logic [3:0][7:0]       w_slew;
  logic [3:0][7:0]       w_cur_next;
  logic [3:0][7:0]       r_cur;
  logic [3:0][WW-1:0]    w_width;
  logic [3:0]            w_match;
  logic [3:0]            w_pwm_next;
  logic [3:0]            r_pwm;
  logic                  r_fs;
  logic                  r_settled;

  assign w_raw = {bus.angle4, bus.angle3, bus.angle2, bus.angle1};

  // The counter parks on its last value in reset, so the first edge after
  // release is a frame boundary.
  assign w_boundary    = (r_cnt == c_last);
  assign w_cnt_next    = w_boundary ? '0 : r_cnt + 1'b1;
  assign w_active_next = w_boundary ? bus.en : r_active;

  // Per-channel clamp, slew and next-cycle pulse level, all evaluated against
  // the counter/position values the next edge will load.
  always_comb begin
    w_tgt      = '0;
    w_diff     = '0;
    w_mag      = '0;
    w_slew     = '0;
    w_cur_next = r_cur;
    w_width    = '0;
    w_match    = '0;
    w_pwm_next = '0;
    for (int i = 0; i < 4; i++) begin
      w_tgt[i]  = (w_raw[i] > c_max) ? c_max : w_raw[i];
      // 9-bit difference; bit 8 is the sign since both operands are 0..180.
      w_diff[i] = {1'b0, w_tgt[i]} - {1'b0, r_cur[i]};
      w_mag[i]  = w_diff[i][8] ? (9'd0 - w_diff[i]) : w_diff[i];
      if ((c_step == 9'd0) || (w_mag[i] <= c_step)) begin
        w_slew[i] = w_tgt[i];
      end else if (w_diff[i][8]) begin
        w_slew[i] = r_cur[i] - c_step8;
      end else begin
        w_slew[i] = r_cur[i] + c_step8;
      end
      if (w_boundary && bus.en) begin
        w_cur_next[i] = w_slew[i];
      end
      w_match[i]    = (w_cur_next[i] == w_tgt[i]);
      w_width[i]    = c_min + WW'(w_cur_next[i]) * c_deg;
      w_pwm_next[i] = w_active_next && (WW'(w_cnt_next) < w_width[i]);
    end
  end

  // Frame counter, frame enable latch and slewed positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= c_last;
      r_active <= 1'b0;
      r_cur    <= {4{c_init}};
    end else begin
      r_cnt    <= w_cnt_next;
      r_active <= w_active_next;
      r_cur    <= w_cur_next;
    end
  end

  // Registered pins and status flags; reset clears pwm asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm     <= '0;
      r_fs      <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_pwm <= w_pwm_next;
      r_fs  <= w_boundary && bus.en;
      if (w_boundary) begin
        r_settled <= &w_match;
      end
    end
  end

  assign bus.pwm         = r_pwm;
  assign bus.cur_angle1  = r_cur[0];
  assign bus.cur_angle2  = r_cur[1];
  assign bus.cur_angle3  = r_cur[2];
  assign bus.cur_angle4  = r_cur[3];
  assign bus.frame_start = r_fs;
  assign bus.settled     = r_settled;

endmodule
`default_nettype wire
